// File: rtl/seq_mul_acc.sv
// +----------------------------------------------------------------------------+
// | Module  : seq_mul_acc                                                      |
// | Brief   : Sequential shift-add multiply-accumulate, out = acc + a*b mod    |
// |           2^(2N), one iteration every CLK_DIV_MULTIPLIER clocks.           |
// |           Optional macro MUL_EARLY_EXIT_EN stops once the multiplier is 0. |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
`default_nettype none

module seq_mul_acc #(
  parameter int N                  = 41,
  parameter int CLK_DIV_MULTIPLIER = 50
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic           MUL_Start_STRB_i,
  output logic           MUL_Done_STRB_o,
  output logic           busy_o,
  input  logic [2*N-1:0] a_i,
  input  logic [2*N-1:0] b_i,
  input  logic [2*N-1:0] acc_i,
  output logic [2*N-1:0] out_o
);

  localparam int W      = 2 * N;
  localparam int ITER_W = $clog2(W + 1);
  localparam int DIV_W  = (CLK_DIV_MULTIPLIER > 1) ? $clog2(CLK_DIV_MULTIPLIER) : 1;

  localparam logic [ITER_W-1:0] C_ITER_LAST = ITER_W'(W - 1);
  localparam logic [DIV_W-1:0]  C_DIV_LAST  = DIV_W'(CLK_DIV_MULTIPLIER - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic [W-1:0]      r_sum;
  logic [W-1:0]      r_mcand;
  logic [W-1:0]      r_mplier;
  logic [ITER_W-1:0] r_iter;
  logic [DIV_W-1:0]  r_div;

  logic              w_load;
  logic              w_tick;
  logic              w_finish;
  logic [W-1:0]      w_sum_next;
  logic [W-1:0]      w_mplier_shr;

  assign w_tick       = (r_div == C_DIV_LAST);
  assign w_sum_next   = r_sum + (r_mplier[0] ? r_mcand : '0);
  assign w_mplier_shr = r_mplier >> 1;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next    = r_state;
    w_load          = 1'b0;
    w_finish        = 1'b0;
    MUL_Done_STRB_o = 1'b0;
    busy_o          = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (MUL_Start_STRB_i) begin
          w_load       = 1'b1;
          w_state_next = ST_RUN;
        end
      end
      ST_RUN: begin
        busy_o = 1'b1;
        if (w_tick) begin
`ifdef MUL_EARLY_EXIT_EN
          // Remaining multiplier bits all zero: further iterations add nothing.
          w_finish = (r_iter == C_ITER_LAST) || (w_mplier_shr == '0);
`else
          w_finish = (r_iter == C_ITER_LAST);
`endif
          if (w_finish) begin
            w_state_next = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        MUL_Done_STRB_o = 1'b1;
        if (MUL_Start_STRB_i) begin
          w_load       = 1'b1;
          w_state_next = ST_RUN;
        end else begin
          w_state_next = ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Unsigned shift-add; the low W bits match the two's complement product.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_sum    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_iter   <= '0;
      r_div    <= '0;
      out_o    <= '0;
    end else begin
      if (w_load) begin
        r_sum    <= acc_i;
        r_mcand  <= a_i;
        r_mplier <= b_i;
        r_iter   <= '0;
        r_div    <= '0;
      end else if (r_state == ST_RUN) begin
        if (w_tick) begin
          r_div    <= '0;
          r_sum    <= w_sum_next;
          r_mcand  <= r_mcand << 1;
          r_mplier <= w_mplier_shr;
          r_iter   <= r_iter + ITER_W'(1);
        end else begin
          r_div <= r_div + DIV_W'(1);
        end
      end
      if (w_finish) begin
        out_o <= w_sum_next;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_seq_mul_acc.sv
// +----------------------------------------------------------------------------+
// | Module  : tb_seq_mul_acc                                                   |
// | Brief   : Directed self-checking bench for seq_mul_acc (N=4, D=1 and D=3). |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_seq_mul_acc;

  logic       clk;
  logic       rst;
  logic       start1, start3;
  logic       done1, done3;
  logic       busy1, busy3;
  logic [7:0] a, b, acc;
  logic [7:0] out1, out3;

  int n_checks = 0;
  int n_fail   = 0;

  seq_mul_acc #(.N(4), .CLK_DIV_MULTIPLIER(1)) u_dut_d1 (
    .clk_i(clk), .rst_i(rst), .MUL_Start_STRB_i(start1), .MUL_Done_STRB_o(done1),
    .busy_o(busy1), .a_i(a), .b_i(b), .acc_i(acc), .out_o(out1)
  );

  seq_mul_acc #(.N(4), .CLK_DIV_MULTIPLIER(3)) u_dut_d3 (
    .clk_i(clk), .rst_i(rst), .MUL_Start_STRB_i(start3), .MUL_Done_STRB_o(done3),
    .busy_o(busy3), .a_i(a), .b_i(b), .acc_i(acc), .out_o(out3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Expected cycle index of the done pulse, counting the start-sample cycle as 0.
  function automatic int exp_lat(input logic [7:0] bv, input int d);
    int k;
`ifdef MUL_EARLY_EXIT_EN
    k = 1;
    for (int i = 0; i < 8; i++) if (bv[i]) k = i + 1;
`else
    k = 8;
`endif
    return k * d + 1;
  endfunction

  function automatic logic get_done(input int sel);
    return (sel == 3) ? done3 : done1;
  endfunction

  function automatic logic get_busy(input int sel);
    return (sel == 3) ? busy3 : busy1;
  endfunction

  // Entered at posedge+1; returns at posedge+1 of cycle 1 of the run.
  task automatic start_op(input int sel, input logic [7:0] av, input logic [7:0] bv,
                          input logic [7:0] accv);
    a = av; b = bv; acc = accv;
    if (sel == 3) start3 = 1'b1; else start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0; start3 = 1'b0;
    a = 8'hA5; b = 8'h3C; acc = 8'h77;
  endtask

  // Returns in the done cycle (or at the timeout bound).
  task automatic wait_done(input int sel, output int cyc, output int busy_cnt);
    cyc = 1;
    busy_cnt = 0;
    while (!get_done(sel) && cyc < 120) begin
      if (get_busy(sel)) busy_cnt++;
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic run_op(input string tag, input int sel, input logic [7:0] av,
                        input logic [7:0] bv, input logic [7:0] accv, input logic [7:0] expv);
    int cyc, bc;
    start_op(sel, av, bv, accv);
    wait_done(sel, cyc, bc);
    check({tag, "_lat"}, cyc, exp_lat(bv, sel));
    check({tag, "_out"}, (sel == 3) ? out3 : out1, expv);
    @(posedge clk); #1;
  endtask

  initial begin
    int cyc, bc, pulses, done_at;
    rst = 1'b1; start1 = 1'b0; start3 = 1'b0; a = '0; b = '0; acc = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out", out1, 8'h00);
    check("rst_busy", busy1, 1'b0);
    check("rst_done", done1, 1'b0);
    rst = 1'b0;
    @(posedge clk); #1;

    // 3*5+0, busy window and hold of out_o
    start_op(1, 8'h03, 8'h05, 8'h00);
    wait_done(1, cyc, bc);
    check("t1_lat", cyc, exp_lat(8'h05, 1));
    check("t1_busy_cycles", bc, exp_lat(8'h05, 1) - 1);
    check("t1_out", out1, 8'h0F);
    while (cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
      if (done1) check("t1_extra_done", done1, 1'b0);
    end
    check("t1_hold", out1, 8'h0F);
    check("t1_idle_busy", busy1, 1'b0);

    run_op("t2_neg_a", 1, 8'hFD, 8'h05, 8'h14, 8'h05);
    run_op("t2_neg_ab", 1, 8'hFD, 8'hFE, 8'h00, 8'h06);
    run_op("t3_wrap", 1, 8'h10, 8'h10, 8'h01, 8'h01);
    run_op("t3_div3", 3, 8'h02, 8'h07, 8'h01, 8'h0F);

    // Chained: second start in the DONE cycle, spurious start at cycle 4 of that run
    start_op(1, 8'h02, 8'h03, 8'h00);
    wait_done(1, cyc, bc);
    check("t4_first_out", out1, 8'h06);
    start_op(1, 8'h01, 8'h85, out1);
    cyc = 1; pulses = 0; done_at = -1;
    while (cyc < 20) begin
      start1 = (cyc == 4);
      if (cyc == 4) begin a = 8'h7F; b = 8'h7F; acc = 8'h00; end
      @(posedge clk); #1;
      start1 = 1'b0;
      cyc++;
      if (done1) begin pulses++; if (done_at < 0) done_at = cyc; end
    end
    check("t4_pulses", pulses, 1);
    check("t4_done_at", done_at, 9);
    check("t4_out", out1, 8'h8B);

    // Reset mid-run aborts
    start_op(1, 8'h03, 8'h85, 8'h00);
    repeat (4) @(posedge clk);
    #1;
    check("t5_busy_before", busy1, 1'b1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("t5_out_cleared", out1, 8'h00);
    check("t5_busy_cleared", busy1, 1'b0);
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (done1) pulses++;
    end
    check("t5_no_done", pulses, 0);
    run_op("t5_after", 1, 8'h03, 8'h05, 8'h01, 8'h10);

    // Multiplier-magnitude vectors (latency depends on MUL_EARLY_EXIT_EN)
    run_op("t6_b01", 1, 8'h03, 8'h01, 8'h02, 8'h05);
    run_op("t6_b00", 1, 8'h03, 8'h00, 8'h21, 8'h21);
    run_op("t6_b05", 1, 8'h03, 8'h05, 8'h00, 8'h0F);
    run_op("t6_bff", 1, 8'h03, 8'hFF, 8'h00, 8'hFD);
    run_op("t6_d3_b01", 3, 8'h04, 8'h01, 8'h01, 8'h05);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
